// File: rtl/sm3_msg_ctrl_if.sv
// Bundle between the SM3 message controller and its register block, message SRAM and compression core.
// The BLK_DONE_CNT signal exists only when SM3_PROGRESS_EN is defined.
interface sm3_msg_ctrl_if #(
    parameter int ADDR_W = 13
) ();
    logic              ENABLE;
    logic [ADDR_W-1:0] SAR_ADDR;
    logic [ADDR_W-1:0] BSR;
    logic              MEM_REN;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_RDATA;
    logic              CF_START;
    logic [511:0]      CF_BLOCK;
    logic [255:0]      CF_VIN;
    logic              CF_DONE;
    logic [255:0]      CF_VOUT;
    logic [255:0]      TEMP_RES;
    logic              SET_STR;
    logic              BUSY;
`ifdef SM3_PROGRESS_EN
    logic [ADDR_W-1:0] BLK_DONE_CNT;
`endif

    modport master (
        input  ENABLE, SAR_ADDR, BSR, MEM_RDATA, CF_DONE, CF_VOUT,
        output MEM_REN, MEM_ADDR, CF_START, CF_BLOCK, CF_VIN, TEMP_RES, SET_STR, BUSY
`ifdef SM3_PROGRESS_EN
        , output BLK_DONE_CNT
`endif
    );

    modport slave (
        output ENABLE, SAR_ADDR, BSR, MEM_RDATA, CF_DONE, CF_VOUT,
        input  MEM_REN, MEM_ADDR, CF_START, CF_BLOCK, CF_VIN, TEMP_RES, SET_STR, BUSY
`ifdef SM3_PROGRESS_EN
        , input BLK_DONE_CNT
`endif
    );
endinterface

// File: rtl/sm3_msg_ctrl.sv
// SM3 message-fetch and chaining controller: reads 16-word blocks from SRAM, drives the compression core,
// chains V across blocks and publishes the digest. Define SM3_PROGRESS_EN to add the BLK_DONE_CNT counter.
module sm3_msg_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic              AHB_HCLK,
    input  logic              AHB_HRESET,
    sm3_msg_ctrl_if.master    bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_KICK = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Chaining values keep word i in bits [32i+31:32i]; word 0 (A) sits in the low bits.
    localparam logic [255:0] IV = {32'hb0fb0e4e, 32'he38dee4d, 32'h163138aa, 32'ha96f30bc,
                                   32'hda8a0600, 32'h172442d7, 32'h4914b2b9, 32'h7380166f};

    logic [2:0]        state_reg;
    logic              enable_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] blk_left_reg;
    logic [4:0]        rd_cnt_reg;
    logic [255:0]      v_reg;
    logic [255:0]      temp_reg;
    logic              set_str_reg;
    logic [31:0]       word_reg [16];

    logic start;
    logic abort;
    logic active;
    logic mem_ren;
    logic cf_accept;

    assign active    = (state_reg == S_LOAD) || (state_reg == S_KICK) || (state_reg == S_WAIT);
    assign start     = bus.ENABLE && !enable_reg && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign abort     = !bus.ENABLE && active;
    // rd_cnt 0..15 issue reads; rd_cnt 16 only captures the last word.
    assign mem_ren   = (state_reg == S_LOAD) && !rd_cnt_reg[4] && bus.ENABLE;
    assign cf_accept = (state_reg == S_WAIT) && bus.CF_DONE && bus.ENABLE;

    assign bus.MEM_REN  = mem_ren;
    assign bus.MEM_ADDR = addr_reg;
    assign bus.CF_START = (state_reg == S_KICK);
    assign bus.CF_VIN   = v_reg;
    assign bus.TEMP_RES = temp_reg;
    assign bus.SET_STR  = set_str_reg;
    assign bus.BUSY     = active;

    // Resetting the edge detector high means an ENABLE already high when reset
    // releases is not mistaken for a fresh request.
    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) begin
            enable_reg <= 1'b1;
        end else begin
            enable_reg <= bus.ENABLE;
        end
    end

    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            blk_left_reg <= '0;
            rd_cnt_reg   <= '0;
            v_reg        <= IV;
            temp_reg     <= '0;
            set_str_reg  <= 1'b0;
        end else if (start) begin
            v_reg        <= IV;
            addr_reg     <= bus.SAR_ADDR;
            blk_left_reg <= bus.BSR;
            rd_cnt_reg   <= '0;
            if (bus.BSR == '0) begin
                state_reg   <= S_DONE;
                temp_reg    <= IV;
                set_str_reg <= 1'b1;
            end else begin
                state_reg   <= S_LOAD;
                set_str_reg <= 1'b0;
            end
        end else if (abort) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    rd_cnt_reg <= rd_cnt_reg + 5'd1;
                    if (mem_ren) begin
                        addr_reg <= addr_reg + ADDR_W'(1);
                    end
                    if (rd_cnt_reg == 5'd16) begin
                        state_reg <= S_KICK;
                    end
                end
                S_KICK: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (cf_accept) begin
                        v_reg        <= bus.CF_VOUT;
                        blk_left_reg <= blk_left_reg - ADDR_W'(1);
                        rd_cnt_reg   <= '0;
                        if (blk_left_reg == ADDR_W'(1)) begin
                            state_reg   <= S_DONE;
                            temp_reg    <= bus.CF_VOUT;
                            set_str_reg <= 1'b1;
                        end else begin
                            state_reg <= S_LOAD;
                        end
                    end
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    // Word gi arrives one cycle after its read, i.e. while rd_cnt equals gi+1.
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
            if (AHB_HRESET) begin
                word_reg[gi] <= '0;
            end else if ((state_reg == S_LOAD) && bus.ENABLE && (rd_cnt_reg == 5'(gi + 1))) begin
                word_reg[gi] <= bus.MEM_RDATA;
            end
        end
        assign bus.CF_BLOCK[511-32*gi -: 32] = word_reg[gi];
    end

`ifdef SM3_PROGRESS_EN
    logic [ADDR_W-1:0] blk_done_cnt_reg;

    always_ff @(posedge AHB_HCLK or posedge AHB_HRESET) begin
        if (AHB_HRESET) begin
            blk_done_cnt_reg <= '0;
        end else if (start) begin
            blk_done_cnt_reg <= '0;
        end else if (cf_accept) begin
            blk_done_cnt_reg <= blk_done_cnt_reg + ADDR_W'(1);
        end
    end

    assign bus.BLK_DONE_CNT = blk_done_cnt_reg;
`endif
endmodule

// File: tb/tb_sm3_msg_ctrl.sv
// Directed bench for sm3_msg_ctrl with an SRAM model and an SM3 compression-function core model.
module tb_sm3_msg_ctrl;
    localparam logic [255:0] IV = {32'hb0fb0e4e, 32'he38dee4d, 32'h163138aa, 32'ha96f30bc,
                                   32'hda8a0600, 32'h172442d7, 32'h4914b2b9, 32'h7380166f};
    localparam logic [255:0] ABC_DIG = {32'h8f4ba8e0, 32'h297da02b, 32'h5cf2f7a2, 32'h4167c487,
                                        32'hdc10e4e2, 32'hd1f2d46b, 32'h62eeedd9, 32'h66c7f0f4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm3_msg_ctrl_if #(.ADDR_W(13)) bus ();
    sm3_msg_ctrl #(.ADDR_W(13)) dut (.AHB_HCLK(clk), .AHB_HRESET(rst), .bus(bus.master));

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:8191];
    logic        core_en = 1'b1;
    logic        core_pend = 1'b0;
    int          core_cnt = 0;
    logic [255:0] core_vin = '0;
    logic [511:0] core_blk = '0;
    logic        core_done = 1'b0;
    logic [255:0] core_vout = '0;
    logic        man_done = 1'b0;
    logic [255:0] man_vout = '0;

    assign bus.CF_DONE = core_done | man_done;
    assign bus.CF_VOUT = man_done ? man_vout : core_vout;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rol(x, 9) ^ rol(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    // Reference SM3 compression; chaining words are low-word-first, block word 0 in the top bits.
    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
        logic [31:0] w [68];
        logic [31:0] w1 [64];
        logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, ff, gg, tj;
        for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
        for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
        a = v[31:0];    bb = v[63:32];  c = v[95:64];   d = v[127:96];
        e = v[159:128]; f = v[191:160]; g = v[223:192]; h = v[255:224];
        for (int j = 0; j < 64; j++) begin
            tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rol(rol(a, 12) + e + rol(tj, j), 7);
            ss2 = ss1 ^ rol(a, 12);
            ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + w1[j];
            tt2 = gg + h + ss1 + w[j];
            d = c; c = rol(bb, 9); bb = a; a = tt1;
            h = g; g = rol(f, 19); f = e; e = p0(tt2);
        end
        return {h, g, f, e, d, c, bb, a} ^ v;
    endfunction

    function automatic logic [511:0] build_blk(input logic [12:0] base);
        logic [511:0] r;
        logic [12:0] ad;
        for (int i = 0; i < 16; i++) begin
            ad = base + 13'(i);
            r[511-32*i -: 32] = mem[ad];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.MEM_REN) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
    end

    always @(posedge clk) begin
        core_done <= 1'b0;
        if (bus.CF_START) begin
            core_pend <= 1'b1;
            core_cnt  <= 3;
            core_vin  <= bus.CF_VIN;
            core_blk  <= bus.CF_BLOCK;
        end else if (core_pend) begin
            if (core_cnt == 0) begin
                core_done <= core_en;
                core_vout <= sm3_cf(core_vin, core_blk);
                core_pend <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    int cyc = 0;
    logic [12:0]  rd_q [$];
    int           rd_cyc_q [$];
    logic [255:0] vin_q [$];
    logic [511:0] blk_q [$];
    int           st_cyc_q [$];
    logic [12:0]  cnt_q [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.MEM_REN) begin
            rd_q.push_back(bus.MEM_ADDR);
            rd_cyc_q.push_back(cyc);
        end
        if (bus.CF_START) begin
            vin_q.push_back(bus.CF_VIN);
            blk_q.push_back(bus.CF_BLOCK);
            st_cyc_q.push_back(cyc);
`ifdef SM3_PROGRESS_EN
            cnt_q.push_back(bus.BLK_DONE_CNT);
`endif
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rd_q.delete(); rd_cyc_q.delete(); vin_q.delete(); blk_q.delete();
        st_cyc_q.delete(); cnt_q.delete();
    endtask

    task automatic launch(input logic [12:0] sar, input logic [12:0] bsr);
        bus.ENABLE = 1'b0;
        tick(1);
        bus.SAR_ADDR = sar;
        bus.BSR = bsr;
        clear_mon();
        bus.ENABLE = 1'b1;
        tick(1);
    endtask

    task automatic wait_set(input string tag);
        int n;
        n = 0;
        while (!bus.SET_STR && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 512'(n < 400), 512'(1));
    endtask

    logic [255:0] v1, wrap_dig, chain3;
    logic [12:0]  ea;

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = (32'(i) * 32'h9e3779b1) ^ 32'h5a5a_c3c3;
        for (int i = 16; i < 32; i++) mem[i] = 32'h0;
        mem[16] = 32'h61626380;
        mem[31] = 32'h00000018;
        bus.ENABLE = 1'b0;
        bus.SAR_ADDR = '0;
        bus.BSR = '0;

        // reset values
        tick(2);
        @(negedge clk);
        chk("rst_set_str", 512'(bus.SET_STR), 512'(0));
        chk("rst_busy", 512'(bus.BUSY), 512'(0));
        chk("rst_ren", 512'(bus.MEM_REN), 512'(0));
        chk("rst_start", 512'(bus.CF_START), 512'(0));
        chk("rst_temp", 512'(bus.TEMP_RES), 512'(0));
        chk("rst_block", bus.CF_BLOCK, 512'(0));
        chk("rst_vin", 512'(bus.CF_VIN), 512'(IV));
        @(posedge clk);
        #1 rst = 1'b0;

        // "abc" single block
        launch(13'h010, 13'd1);
        wait_set("abc_timeout");
        chk("abc_nreads", 512'(rd_q.size()), 512'(16));
        for (int i = 0; i < 16; i++) chk("abc_addr", 512'(rd_q[i]), 512'(13'h010 + 13'(i)));
        chk("abc_nstart", 512'(vin_q.size()), 512'(1));
        chk("abc_vin", 512'(vin_q[0]), 512'(IV));
        chk("abc_block", blk_q[0], build_blk(13'h010));
        chk("abc_kick_lat", 512'(st_cyc_q[0] - rd_cyc_q[0]), 512'(17));
        chk("abc_digest", 512'(bus.TEMP_RES), 512'(ABC_DIG));
        chk("abc_busy", 512'(bus.BUSY), 512'(0));

        // ENABLE held high in DONE never restarts
        clear_mon();
        tick(6);
        chk("hold_nreads", 512'(rd_q.size()), 512'(0));
        chk("hold_set_str", 512'(bus.SET_STR), 512'(1));

        // BSR = 0 finishes next cycle with IV
        launch(13'h020, 13'd0);
        @(negedge clk);
        chk("bsr0_temp", 512'(bus.TEMP_RES), 512'(IV));
        chk("bsr0_set_str", 512'(bus.SET_STR), 512'(1));
        tick(4);
        chk("bsr0_nreads", 512'(rd_q.size()), 512'(0));
        chk("bsr0_nstart", 512'(vin_q.size()), 512'(0));
        chk("bsr0_busy", 512'(bus.BUSY), 512'(0));

        // address wrap across the top of SRAM
        v1 = sm3_cf(IV, build_blk(13'h1FF8));
        wrap_dig = sm3_cf(v1, build_blk(13'h0008));
        launch(13'h1FF8, 13'd2);
        wait_set("wrap_timeout");
        chk("wrap_nreads", 512'(rd_q.size()), 512'(32));
        for (int i = 0; i < 32; i++) begin
            ea = 13'h1FF8 + 13'(i);
            chk("wrap_addr", 512'(rd_q[i]), 512'(ea));
        end
        chk("wrap_nstart", 512'(vin_q.size()), 512'(2));
        chk("wrap_vin0", 512'(vin_q[0]), 512'(IV));
        chk("wrap_vin1", 512'(vin_q[1]), 512'(v1));
        chk("wrap_digest", 512'(bus.TEMP_RES), 512'(wrap_dig));

        // abort while waiting on block 1 of 3, then a stray CF_DONE
        core_en = 1'b0;
        launch(13'h100, 13'd3);
        begin
            int n;
            n = 0;
            while (vin_q.size() < 1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("abort_kick_timeout", 512'(n < 100), 512'(1));
        end
        tick(4);
        chk("abort_busy_wait", 512'(bus.BUSY), 512'(1));
        bus.ENABLE = 1'b0;
        clear_mon();
        tick(1);
        man_done = 1'b1;
        man_vout = {8{32'hdeadbeef}};
        tick(1);
        man_done = 1'b0;
        tick(4);
        chk("abort_busy", 512'(bus.BUSY), 512'(0));
        chk("abort_set_str", 512'(bus.SET_STR), 512'(0));
        chk("abort_temp", 512'(bus.TEMP_RES), 512'(wrap_dig));
        chk("abort_vin", 512'(bus.CF_VIN), 512'(IV));
        chk("abort_nreads", 512'(rd_q.size()), 512'(0));
        core_en = 1'b1;

        // abort during LOAD drops MEM_REN in the same cycle
        launch(13'h100, 13'd3);
        tick(4);
        bus.ENABLE = 1'b0;
        #1;
        chk("abort_ld_ren", 512'(bus.MEM_REN), 512'(0));
        chk("abort_ld_busy", 512'(bus.BUSY), 512'(1));
        tick(1);
        chk("abort_ld_idle", 512'(bus.BUSY), 512'(0));

        // full three-block restart from SAR_ADDR with V = IV
        chain3 = IV;
        for (int i = 0; i < 3; i++) chain3 = sm3_cf(chain3, build_blk(13'h100 + 13'(16*i)));
        launch(13'h100, 13'd3);
        wait_set("run3_timeout");
        chk("run3_first_addr", 512'(rd_q[0]), 512'(13'h100));
        chk("run3_nreads", 512'(rd_q.size()), 512'(48));
        chk("run3_vin0", 512'(vin_q[0]), 512'(IV));
        chk("run3_digest", 512'(bus.TEMP_RES), 512'(chain3));
`ifdef SM3_PROGRESS_EN
        for (int i = 0; i < 3; i++) chk("cnt_step", 512'(cnt_q[i]), 512'(i));
        chk("cnt_final", 512'(bus.BLK_DONE_CNT), 512'(3));
`endif

        // reset during the 8th LOAD read
        launch(13'h040, 13'd1);
`ifdef SM3_PROGRESS_EN
        chk("cnt_restart", 512'(bus.BLK_DONE_CNT), 512'(0));
`endif
        begin
            int n;
            n = 0;
            while (rd_q.size() < 8 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rst8_timeout", 512'(n < 50), 512'(1));
        end
        #1 rst = 1'b1;
        #1;
        chk("rst8_ren", 512'(bus.MEM_REN), 512'(0));
        chk("rst8_busy", 512'(bus.BUSY), 512'(0));
        chk("rst8_set_str", 512'(bus.SET_STR), 512'(0));
        chk("rst8_temp", 512'(bus.TEMP_RES), 512'(0));
        chk("rst8_block", bus.CF_BLOCK, 512'(0));
        chk("rst8_vin", 512'(bus.CF_VIN), 512'(IV));
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        tick(20);
        chk("rst8_no_restart", 512'(rd_q.size()), 512'(0));
        chk("rst8_idle", 512'(bus.BUSY), 512'(0));

        // a fresh edge after reset runs normally
        launch(13'h010, 13'd1);
        wait_set("fresh_timeout");
        chk("fresh_digest", 512'(bus.TEMP_RES), 512'(ABC_DIG));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end
endmodule
